// File: rtl/fp_divider.sv
// fp_divider: iterative IEEE-754 single-precision divider, radix-2 restoring.
// Optional round-to-nearest-even when FPDIV_RNE_EN is defined; else truncation.
module fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  localparam int QBITS = 26;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [24:0]       rem_q, rem_d;
  logic [QBITS-1:0]  quo_q, quo_d;
  logic [23:0]       mb_q, mb_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              spec_q, spec_d;
  logic [31:0]       res_q, res_d;
  logic [4:0]        flg_q, flg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       result_q, result_d;
  logic [4:0]        fflags_q, fflags_d;

  logic        a_nan, a_inf, a_zero;
  logic        b_nan, b_inf, b_zero;
  logic        sgn_in, spec;
  logic [31:0] spec_res;
  logic [4:0]  spec_flg;

  // operand classification on the raw inputs; exponent 0 counts as zero
  always_comb begin
    a_zero   = (a[30:23] == 8'd0);
    a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_zero   = (b[30:23] == 8'd0);
    b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sgn_in   = a[31] ^ b[31];
    spec     = 1'b1;
    spec_res = 32'd0;
    spec_flg = 5'd0;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_res = 32'h7FC00000;
      spec_flg = 5'b10000;
    end else if (a_inf) begin
      spec_res = {sgn_in, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_res = {sgn_in, 8'hFF, 23'd0};
      spec_flg = 5'b01000;
    end else if (b_inf || a_zero) begin
      spec_res = {sgn_in, 31'd0};
    end else begin
      spec     = 1'b0;
    end
  end

  logic [22:0]       n_frac;
  logic              n_g, n_s, n_inc, n_nx;
  logic [23:0]       n_sum;
  logic signed [9:0] n_exp, n_exp_r;
  logic [31:0]       n_res;
  logic [4:0]        n_flg;

  // normalize the raw quotient, round, then range-check the exponent
  always_comb begin
    if (quo_q[QBITS-1]) begin
      n_frac = quo_q[24:2];
      n_g    = quo_q[1];
      n_s    = quo_q[0] | (rem_q != 25'd0);
      n_exp  = exp_q;
    end else begin
      n_frac = quo_q[23:1];
      n_g    = quo_q[0];
      n_s    = (rem_q != 25'd0);
      n_exp  = exp_q - 10'sd1;
    end
`ifdef FPDIV_RNE_EN
    n_inc   = n_g & (n_s | n_frac[0]);
`else
    n_inc   = 1'b0;
`endif
    n_sum   = {1'b0, n_frac} + {23'd0, n_inc};
    n_exp_r = n_exp + $signed({9'd0, n_sum[23]});
    n_nx    = n_g | n_s;
    if (n_exp_r >= 10'sd255) begin
      n_res = {sign_q, 8'hFF, 23'd0};
      n_flg = 5'b00101;
    end else if (n_exp_r <= 10'sd0) begin
      n_res = {sign_q, 31'd0};
      n_flg = 5'b00011;
    end else begin
      n_res = {sign_q, n_exp_r[7:0], n_sum[22:0]};
      n_flg = {4'd0, n_nx};
    end
  end

  logic        ge;
  logic [23:0] rsub;

  // control FSM and one restoring step per DIV cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    mb_d     = mb_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    spec_d   = spec_q;
    res_d    = res_q;
    flg_d    = flg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    fflags_d = fflags_q;
    ge       = (rem_q >= {1'b0, mb_q});
    rsub     = ge ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          sign_d  = sgn_in;
          spec_d  = spec;
          res_d   = spec_res;
          flg_d   = spec_flg;
          mb_d    = {1'b1, b[22:0]};
          rem_d   = {2'b01, a[22:0]};
          quo_d   = '0;
          cnt_d   = 5'd0;
          exp_d   = $signed({2'b00, a[30:23]})
                  - $signed({2'b00, b[30:23]})
                  + 10'sd127;
          state_d = spec ? S_NORM : S_DIV;
        end
      end
      S_DIV: begin
        rem_d = {rsub, 1'b0};
        quo_d = {quo_q[QBITS-2:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QBITS - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (!spec_q) begin
          res_d = n_res;
          flg_d = n_flg;
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        result_d = res_q;
        fflags_d = flg_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers; reset discards any division in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 25'd0;
      quo_q    <= '0;
      mb_q     <= 24'd0;
      exp_q    <= 10'sd0;
      sign_q   <= 1'b0;
      spec_q   <= 1'b0;
      res_q    <= 32'd0;
      flg_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      fflags_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      mb_q     <= mb_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      spec_q   <= spec_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign fflags = fflags_q;

endmodule
